// File: rtl/mrd_in_framer.sv
// mrd_in_framer: input framer in front of the mixed-radix DFT memory top.
// Accepts a ready/valid sample stream and checks that each packet's dftpts is
// a legal 2/3/5-smooth size in range. It holds the first sample while the
// memory is busy, then forwards exactly dftpts samples as sop/valid/eop.
// Short packets are zero-padded, long ones truncated, and illegal ones dropped.
// Build option: define MRD_IN_FRAMER_STATS_EN to enable pkt_cnt/drop_cnt.
// Without it both counters read 0 and no counter logic is built.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a sop sample; non-sop samples are discarded
// CHECK    | factoring dftpts by 2/3/5 to decide legality
// WAIT_MEM | legal packet held until the memory top is idle
// STREAM   | forwarding accepted samples with 1-cycle latency
// PAD      | emitting zero samples after an early eop
// DROP     | discarding input up to and including the next eop

module mrd_in_framer #(
    parameter int W_DATA  = 18,
    parameter int W_PTS   = 12,
    parameter int MIN_PTS = 12,
    parameter int MAX_PTS = 1200,
    parameter int CHK_MAX = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sop,
    input  logic              s_eop,
    input  logic [W_DATA-1:0] s_real,
    input  logic [W_DATA-1:0] s_imag,
    input  logic [W_PTS-1:0]  s_dftpts,
    input  logic              mem_busy,
    output logic              m_valid,
    output logic              m_sop,
    output logic              m_eop,
    output logic [W_DATA-1:0] m_real,
    output logic [W_DATA-1:0] m_imag,
    output logic [W_PTS-1:0]  m_dftpts,
    output logic              err_pts,
    output logic              err_len,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int W_CHK = $clog2(CHK_MAX + 1);
    localparam int W_EXT = W_PTS + 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WAIT_MEM,
        ST_STREAM,
        ST_PAD,
        ST_DROP
    } state_t;

    state_t             r_state;
    logic               r_s_ready;
    logic [W_DATA-1:0]  r_hold_real;
    logic [W_DATA-1:0]  r_hold_imag;
    logic               r_hold_eop;
    logic [W_PTS-1:0]   r_pts;
    logic [W_PTS-1:0]   r_div;
    logic [W_CHK-1:0]   r_chk;
    logic [W_PTS-1:0]   r_cnt;
    logic               r_m_valid;
    logic               r_m_sop;
    logic               r_m_eop;
    logic [W_DATA-1:0]  r_m_real;
    logic [W_DATA-1:0]  r_m_imag;
    logic [W_PTS-1:0]   r_m_dftpts;
    logic               r_err_pts;
    logic               r_err_len;

    logic               w_accept;
    logic [W_PTS-1:0]   w_last_idx;
    logic               w_range_ok;
    logic [W_PTS-1:0]   w_q2;
    logic [W_PTS-1:0]   w_q3;
    logic [W_PTS-1:0]   w_q5;
    logic               w_div2;
    logic               w_div3;
    logic               w_div5;

`ifdef MRD_IN_FRAMER_STATS_EN
    logic [15:0]        r_pkt_cnt;
    logic [15:0]        r_drop_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    // Handshake, index and factor-test helpers. The 3/5 divisibility test
    // multiplies the quotient back and compares it to r, so only exact
    // divisions are taken.
    always_comb begin
        w_accept   = s_valid & r_s_ready;
        w_last_idx = r_pts - W_PTS'(1);
        w_range_ok = (r_pts >= W_PTS'(MIN_PTS)) && (r_pts <= W_PTS'(MAX_PTS));
        w_q2       = r_div >> 1;
        w_q3       = r_div / W_PTS'(3);
        w_q5       = r_div / W_PTS'(5);
        w_div2     = ~r_div[0];
        w_div3     = (W_EXT'(w_q3) * W_EXT'(3)) == W_EXT'(r_div);
        w_div5     = (W_EXT'(w_q5) * W_EXT'(5)) == W_EXT'(r_div);
    end

    // Framing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_s_ready   <= 1'b0;
            r_hold_real <= '0;
            r_hold_imag <= '0;
            r_hold_eop  <= 1'b0;
            r_pts       <= '0;
            r_div       <= '0;
            r_chk       <= '0;
            r_cnt       <= '0;
            r_m_valid   <= 1'b0;
            r_m_sop     <= 1'b0;
            r_m_eop     <= 1'b0;
            r_m_real    <= '0;
            r_m_imag    <= '0;
            r_m_dftpts  <= '0;
            r_err_pts   <= 1'b0;
            r_err_len   <= 1'b0;
`ifdef MRD_IN_FRAMER_STATS_EN
            r_pkt_cnt   <= '0;
            r_drop_cnt  <= '0;
`endif
        end else begin
            r_m_valid <= 1'b0;
            r_m_sop   <= 1'b0;
            r_m_eop   <= 1'b0;
            r_err_pts <= 1'b0;
            r_err_len <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_s_ready <= 1'b1;
                    if (w_accept && s_sop) begin
                        r_hold_real <= s_real;
                        r_hold_imag <= s_imag;
                        r_hold_eop  <= s_eop;
                        r_pts       <= s_dftpts;
                        r_div       <= s_dftpts;
                        r_chk       <= '0;
                        r_s_ready   <= 1'b0;
                        r_state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_range_ok && r_div == W_PTS'(1)) begin
                        r_state <= ST_WAIT_MEM;
                    end else if (w_range_ok && r_chk < W_CHK'(CHK_MAX) &&
                                 (w_div2 || w_div3 || w_div5)) begin
                        if (w_div2)      r_div <= w_q2;
                        else if (w_div3) r_div <= w_q3;
                        else             r_div <= w_q5;
                        r_chk <= r_chk + W_CHK'(1);
                    end else begin
                        r_err_pts <= 1'b1;
`ifdef MRD_IN_FRAMER_STATS_EN
                        r_drop_cnt <= sat_inc(r_drop_cnt);
`endif
                        r_s_ready <= 1'b1;
                        r_state   <= r_hold_eop ? ST_IDLE : ST_DROP;
                    end
                end
                ST_WAIT_MEM: begin
                    if (!mem_busy) begin
                        r_m_valid  <= 1'b1;
                        r_m_sop    <= 1'b1;
                        r_m_real   <= r_hold_real;
                        r_m_imag   <= r_hold_imag;
                        r_m_dftpts <= r_pts;
                        r_cnt      <= W_PTS'(1);
                        if (r_hold_eop) begin
                            // one-sample packet: the rest is padding
                            r_err_len <= 1'b1;
                            r_state   <= ST_PAD;
                        end else begin
                            r_s_ready <= 1'b1;
                            r_state   <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_accept) begin
                        r_m_valid <= 1'b1;
                        r_m_real  <= s_real;
                        r_m_imag  <= s_imag;
                        r_cnt     <= r_cnt + W_PTS'(1);
                        if (r_cnt == w_last_idx) begin
                            r_m_eop <= 1'b1;
`ifdef MRD_IN_FRAMER_STATS_EN
                            r_pkt_cnt <= sat_inc(r_pkt_cnt);
`endif
                            if (!s_eop) begin
                                r_err_len <= 1'b1;
                                r_state   <= ST_DROP;
                            end else begin
                                r_state   <= ST_IDLE;
                            end
                        end else if (s_eop) begin
                            r_err_len <= 1'b1;
                            r_s_ready <= 1'b0;
                            r_state   <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    r_m_valid <= 1'b1;
                    r_m_real  <= '0;
                    r_m_imag  <= '0;
                    r_cnt     <= r_cnt + W_PTS'(1);
                    if (r_cnt == w_last_idx) begin
                        r_m_eop   <= 1'b1;
`ifdef MRD_IN_FRAMER_STATS_EN
                        r_pkt_cnt <= sat_inc(r_pkt_cnt);
`endif
                        r_s_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    r_s_ready <= 1'b1;
                    if (w_accept && s_eop) r_state <= ST_IDLE;
                end
                default: begin
                    r_s_ready <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready  = r_s_ready;
    assign m_valid  = r_m_valid;
    assign m_sop    = r_m_sop;
    assign m_eop    = r_m_eop;
    assign m_real   = r_m_real;
    assign m_imag   = r_m_imag;
    assign m_dftpts = r_m_dftpts;
    assign err_pts  = r_err_pts;
    assign err_len  = r_err_len;

`ifdef MRD_IN_FRAMER_STATS_EN
    assign pkt_cnt  = r_pkt_cnt;
    assign drop_cnt = r_drop_cnt;
`else
    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
`endif

endmodule
